bin_map_reader: RTL and testbench
=================================

BIN_MAP_READER -- requirements
Module: bin_map_reader

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, meaning frame width in pixels.
REQ-002 SHALL have parameter V_PIXELS, default 480, meaning frame height in pixels.
REQ-003 SHALL have parameter RD_LATENCY, default 2, meaning cycles from addr/rd_en to valid bin_dout.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin one full-frame scan.
REQ-007 SHALL have port busy  output  1  high from accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse after last result accepted.
REQ-009 SHALL have port addr  output  19  bin-map BRAM read address, y*H_PIXELS+x.
REQ-010 SHALL have port rd_en  output  1  BRAM read enable; write enable is never driven.
REQ-011 SHALL have port bin_dout  input  3  bin label read from BRAM, 0 = unlabelled.
REQ-012 SHALL have port res_valid  output  1  result fields valid.
REQ-013 SHALL have port res_ready  input  1  consumer accepts result.
REQ-014 SHALL have port res_bin  output  3  bin number of the result, 1..7.
REQ-015 SHALL have port res_count  output  19  pixels carrying that label.
REQ-016 SHALL have port res_sum_x  output  28  sum of x of those pixels.
REQ-017 SHALL have port res_sum_y  output  28  sum of y of those pixels.

Function
REQ-018 SHALL implement states IDLE, SCAN, DRAIN, REPORT, FINISH.
REQ-019 IDLE: start high at a clock edge SHALL clear all 7x3 accumulators, set busy, and enter SCAN; start is ignored in every other state.
REQ-020 SCAN: rd_en SHALL be high for exactly H_PIXELS*V_PIXELS consecutive cycles, the first beginning the cycle after start is sampled.
REQ-021 SCAN: addr SHALL start at 0 and increment by 1 per cycle in raster order; x wraps 639->0 and increments y.
REQ-022 SHALL delay x, y and a valid flag through a RD_LATENCY-stage pipeline so that each bin_dout pairs with its own coordinates.
REQ-023 SHALL, for each valid sample with bin_dout=b and b!=0, increment count[b] and add x to sum_x[b] and y to sum_y[b]. bin 0 is discarded.
REQ-024 SHALL not saturate or wrap any accumulator; the widths cover a full frame in one bin (count 307200, sum_x <2^28, sum_y <2^28).
REQ-025 SHALL, after the last rd_en cycle, enter DRAIN for RD_LATENCY cycles with rd_en low, then enter REPORT.
REQ-026 REPORT: SHALL present bins 1..7 in ascending order with res_valid high; the transfer occurs on res_valid&&res_ready.
REQ-027 REPORT: while res_valid is high and res_ready is low, res_bin, res_count, res_sum_x and res_sum_y SHALL stay stable; res_valid SHALL NOT drop.
REQ-028 REPORT: after the bin-7 transfer SHALL enter FINISH: done high one cycle, busy low, and return to IDLE the next cycle.
REQ-029 Throughput: one result per cycle when res_ready is held high; minimum total scan-to-done is H*V+RD_LATENCY+8 cycles.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE and set busy, done, rd_en, res_valid, addr, res_bin, res_count, res_sum_x, res_sum_y and all accumulators and pipeline valids to 0.
REQ-031 Reset mid-scan or mid-report SHALL abandon the frame; no partial result is emitted after release.
REQ-032 After reset_n rises, the first start SHALL be accepted on the first clock edge at which it is sampled high.

Structure
REQ-033 The shared package bin_map_pkg SHALL hold H_PIXELS, V_PIXELS, ADDR_W=19, BIN_W=3, NUM_BINS=7 and the state enumeration; these constants are shared with the contour writer.
REQ-034 Raster x/y/addr counting SHALL be a sub-module, raster_addr_gen, with ports clk, reset_n, run, x, y, addr, last.

Verification
REQ-035 All-zero map, start, res_ready=1 -> seven results bins 1..7, every count/sum 0; done high exactly 307200+2+8 cycles after start.
REQ-036 Single pixel bin 3 at (10,20), addr 12810 -> bin3 count=1, sum_x=10, sum_y=20; all other bins 0.
REQ-037 Whole frame bin 7 -> bin7 count=307200, sum_x=98150400, sum_y=73574400; bins 1..6 zero.
REQ-038 res_ready low for 5 cycles during the bin-2 result -> res_valid stays high and fields are unchanged; bin 3 follows only after the bin-2 handshake.
REQ-039 reset_n pulsed low at scan cycle 1000 -> all outputs 0 immediately; a restarted scan yields correct results with no stale accumulation.
REQ-040 start pulsed during SCAN and during REPORT -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/bin_map_pkg.sv
// bin_map_pkg: frame geometry, bin-map field widths and reader states shared with the contour writer
package bin_map_pkg;
  localparam int H_PIXELS = 640;
  localparam int V_PIXELS = 480;
  localparam int ADDR_W = 19;
  localparam int BIN_W = 3;
  localparam int NUM_BINS = 7;
  localparam int CNT_W = 19;
  localparam int SUM_W = 28;
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, REPORT, FINISH} state_e;
endpackage

// File: rtl/raster_addr_gen.sv
// raster_addr_gen: raster-order x/y/address counter; advances while run is high and wraps to 0 after the last pixel
module raster_addr_gen #(
  parameter int H_PIXELS = bin_map_pkg::H_PIXELS,
  parameter int V_PIXELS = bin_map_pkg::V_PIXELS,
  parameter int X_W = $clog2(H_PIXELS),
  parameter int Y_W = $clog2(V_PIXELS)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [bin_map_pkg::ADDR_W-1:0] addr,
  output logic last
);
  import bin_map_pkg::*;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [ADDR_W-1:0] addr_q;
  logic eol;
  assign eol = x_q == X_W'(H_PIXELS - 1);
  assign last = addr_q == ADDR_W'(H_PIXELS * V_PIXELS - 1);
  assign x = x_q;
  assign y = y_q;
  assign addr = addr_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      addr_q <= '0;
    end else if (run) begin
      x_q <= eol ? '0 : x_q + X_W'(1);
      y_q <= last ? '0 : eol ? y_q + Y_W'(1) : y_q;
      addr_q <= last ? '0 : addr_q + ADDR_W'(1);
    end
endmodule

// File: rtl/bin_map_reader.sv
// bin_map_reader: scans the bin-map BRAM once per start and reports per-bin pixel count and x/y sums for bins 1..7
module bin_map_reader #(
  parameter int H_PIXELS = bin_map_pkg::H_PIXELS,
  parameter int V_PIXELS = bin_map_pkg::V_PIXELS,
  parameter int RD_LATENCY = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic [bin_map_pkg::ADDR_W-1:0] addr,
  output logic rd_en,
  input  logic [bin_map_pkg::BIN_W-1:0] bin_dout,
  output logic res_valid,
  input  logic res_ready,
  output logic [bin_map_pkg::BIN_W-1:0] res_bin,
  output logic [bin_map_pkg::CNT_W-1:0] res_count,
  output logic [bin_map_pkg::SUM_W-1:0] res_sum_x,
  output logic [bin_map_pkg::SUM_W-1:0] res_sum_y
);
  import bin_map_pkg::*;
  localparam int X_W = $clog2(H_PIXELS);
  localparam int Y_W = $clog2(V_PIXELS);
  localparam int D_W = $clog2(RD_LATENCY + 1);
  state_e state_q;
  logic busy_q, done_q, rd_en_q, res_valid_q, clr;
  logic [D_W-1:0] drain_q;
  logic [BIN_W-1:0] res_bin_q, nxt_bin;
  logic [CNT_W-1:0] res_count_q, sel_cnt;
  logic [SUM_W-1:0] res_sum_x_q, res_sum_y_q, sel_sx, sel_sy;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic last;
  logic v_q [RD_LATENCY];
  logic [X_W-1:0] px_q [RD_LATENCY];
  logic [Y_W-1:0] py_q [RD_LATENCY];
  logic [CNT_W-1:0] cnt_q [1:NUM_BINS];
  logic [CNT_W-1:0] cnt_d [1:NUM_BINS];
  logic [SUM_W-1:0] sx_q [1:NUM_BINS];
  logic [SUM_W-1:0] sx_d [1:NUM_BINS];
  logic [SUM_W-1:0] sy_q [1:NUM_BINS];
  logic [SUM_W-1:0] sy_d [1:NUM_BINS];
  assign busy = busy_q;
  assign done = done_q;
  assign rd_en = rd_en_q;
  assign res_valid = res_valid_q;
  assign res_bin = res_bin_q;
  assign res_count = res_count_q;
  assign res_sum_x = res_sum_x_q;
  assign res_sum_y = res_sum_y_q;
  assign clr = state_q == IDLE && start;
  raster_addr_gen #(
    .H_PIXELS(H_PIXELS),
    .V_PIXELS(V_PIXELS),
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_raster (
    .clk(clk),
    .reset_n(reset_n),
    .run(rd_en_q),
    .x(x),
    .y(y),
    .addr(addr),
    .last(last)
  );
  // Coordinates ride alongside the BRAM read so each bin_dout meets its own pixel.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        v_q[i] <= 1'b0;
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      v_q[0] <= rd_en_q;
      px_q[0] <= x;
      py_q[0] <= y;
      for (int i = 1; i < RD_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        px_q[i] <= px_q[i-1];
        py_q[i] <= py_q[i-1];
      end
    end
  always_comb begin
    cnt_d = cnt_q;
    sx_d = sx_q;
    sy_d = sy_q;
    for (int b = 1; b <= NUM_BINS; b++)
      if (clr) begin
        cnt_d[b] = '0;
        sx_d[b] = '0;
        sy_d[b] = '0;
      end else if (v_q[RD_LATENCY-1] && bin_dout == BIN_W'(b)) begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
        sx_d[b] = sx_q[b] + SUM_W'(px_q[RD_LATENCY-1]);
        sy_d[b] = sy_q[b] + SUM_W'(py_q[RD_LATENCY-1]);
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int b = 1; b <= NUM_BINS; b++) begin
        cnt_q[b] <= '0;
        sx_q[b] <= '0;
        sy_q[b] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  // Reading the next-state accumulators lets bin 1 load on the same edge as the final sample.
  always_comb begin
    nxt_bin = state_q == REPORT ? res_bin_q + BIN_W'(1) : BIN_W'(1);
    sel_cnt = '0;
    sel_sx = '0;
    sel_sy = '0;
    for (int b = 1; b <= NUM_BINS; b++)
      if (nxt_bin == BIN_W'(b)) begin
        sel_cnt = cnt_d[b];
        sel_sx = sx_d[b];
        sel_sy = sy_d[b];
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_en_q <= 1'b0;
      drain_q <= '0;
      res_valid_q <= 1'b0;
      res_bin_q <= '0;
      res_count_q <= '0;
      res_sum_x_q <= '0;
      res_sum_y_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE:
          if (start) begin
            busy_q <= 1'b1;
            rd_en_q <= 1'b1;
            state_q <= SCAN;
          end
        SCAN:
          if (last) begin
            rd_en_q <= 1'b0;
            drain_q <= '0;
            state_q <= DRAIN;
          end
        DRAIN:
          if (drain_q == D_W'(RD_LATENCY - 1)) begin
            res_valid_q <= 1'b1;
            res_bin_q <= nxt_bin;
            res_count_q <= sel_cnt;
            res_sum_x_q <= sel_sx;
            res_sum_y_q <= sel_sy;
            state_q <= REPORT;
          end else begin
            drain_q <= drain_q + D_W'(1);
          end
        REPORT:
          if (res_ready && res_bin_q == BIN_W'(NUM_BINS)) begin
            res_valid_q <= 1'b0;
            res_bin_q <= '0;
            res_count_q <= '0;
            res_sum_x_q <= '0;
            res_sum_y_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state_q <= FINISH;
          end else if (res_ready) begin
            res_bin_q <= nxt_bin;
            res_count_q <= sel_cnt;
            res_sum_x_q <= sel_sx;
            res_sum_y_q <= sel_sy;
          end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bin_map_reader.sv
// tb_bin_map_reader: scoreboard bench on a reduced frame, with a latency-matched BRAM model and per-frame reference sums
module tb_bin_map_reader;
  localparam int H = 16;
  localparam int V = 12;
  localparam int L = 2;
  localparam int N = H * V;
  typedef struct packed {
    logic [2:0] b;
    logic [18:0] c;
    logic [27:0] sx;
    logic [27:0] sy;
  } res_t;
  logic clk, reset_n, start, busy, done, rd_en, res_valid, res_ready;
  logic [18:0] addr, res_count;
  logic [2:0] bin_dout, res_bin;
  logic [27:0] res_sum_x, res_sum_y;
  logic [2:0] mem [N];
  logic [2:0] pipe [L];
  res_t exp_q [$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int stall_left = 0;
  bin_map_reader #(.H_PIXELS(H), .V_PIXELS(V), .RD_LATENCY(L)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .busy(busy),
    .done(done),
    .addr(addr),
    .rd_en(rd_en),
    .bin_dout(bin_dout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_bin(res_bin),
    .res_count(res_count),
    .res_sum_x(res_sum_x),
    .res_sum_y(res_sum_y)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // BRAM: L-cycle read latency; output is junk whenever rd_en was low.
  always @(posedge clk) begin
    pipe[0] <= rd_en ? mem[int'(addr) % N] : 3'($urandom);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bin_dout = pipe[L-1];
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic outs_zero(string name);
    chk(name, {busy, done, rd_en, res_valid, addr, res_bin, res_count, res_sum_x, res_sum_y}, '0);
  endtask
  task automatic push_exp();
    res_t e;
    for (int b = 1; b <= 7; b++) begin
      e = '0;
      e.b = 3'(b);
      for (int a = 0; a < N; a++)
        if (int'(mem[a]) == b) begin
          e.c = e.c + 19'd1;
          e.sx = e.sx + 28'(a % H);
          e.sy = e.sy + 28'(a / H);
        end
      exp_q.push_back(e);
    end
  endtask
  task automatic fill(int v);
    for (int a = 0; a < N; a++) mem[a] = 3'(v);
  endtask
  task automatic rand_map();
    for (int a = 0; a < N; a++) mem[a] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
  endtask
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
    end
  endtask
  task automatic frame(int mode);
    ready_mode = mode;
    stall_left = 5;
    push_exp();
    pulse_start();
    wait_done(4000);
    repeat (2) @(posedge clk);
    #1;
  endtask
  // Consumer: always ready, random backpressure, or a 5-cycle stall on the bin-2 result.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) res_ready = $urandom_range(0, 3) != 0;
      else if (ready_mode == 2 && res_valid && res_bin == 3'd2 && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else res_ready = 1'b1;
    end
  end
  logic hold_v = 1'b0;
  logic [77:0] hold;
  int start_cyc, rd_cnt, addr_bad, exp_addr, stall_seen;
  always @(negedge clk) begin
    res_t e;
    if (!reset_n) hold_v = 1'b0;
    else begin
      if (hold_v) chk("stall_hold", {res_valid, res_bin, res_count, res_sum_x, res_sum_y}, {1'b1, hold});
      hold_v = res_valid && !res_ready;
      hold = {res_bin, res_count, res_sum_x, res_sum_y};
      if (hold_v) stall_seen++;
      if (start && !busy && !done) begin
        start_cyc = cyc;
        rd_cnt = 0;
        addr_bad = 0;
        exp_addr = 0;
        stall_seen = 0;
      end
      if (rd_en) begin
        rd_cnt++;
        if (int'(addr) != exp_addr) addr_bad++;
        exp_addr++;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got bin %0d, expected no result", res_bin);
        end else begin
          e = exp_q.pop_front();
          chk("result", {res_bin, res_count, res_sum_x, res_sum_y}, e);
        end
      end
      if (done) begin
        done_cnt++;
        chk("queue_drained", exp_q.size(), 0);
        chk("rd_en_cycles", rd_cnt, N);
        chk("addr_seq_errs", addr_bad, 0);
        if (ready_mode == 0) chk("start_to_done", cyc - start_cyc, N + L + 8);
        if (ready_mode == 2) chk("stall_cycles", stall_seen, 5);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected bench to complete");
    $fatal(1);
  end
  initial begin
    int n0, k;
    reset_n = 1'b0;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs_zero("reset_state");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    frame(0);
    mem[5 * H + 10] = 3'd3;
    frame(0);
    fill(7);
    frame(0);
    repeat (3) begin
      rand_map();
      frame(1);
    end
    rand_map();
    frame(2);
    // Abandon a frame mid-scan; nothing from it may surface after release.
    rand_map();
    ready_mode = 0;
    push_exp();
    pulse_start();
    repeat (100) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 outs_zero("async_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    outs_zero("idle_after_reset");
    rand_map();
    frame(0);
    // Stray starts during SCAN and REPORT must not launch another frame.
    rand_map();
    ready_mode = 1;
    n0 = done_cnt;
    push_exp();
    pulse_start();
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (!res_valid && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4000);
    repeat (N + 50) @(posedge clk);
    chk("one_done_per_start", done_cnt - n0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
